// File: rtl/sgdmac_desc_fetcher_pv.sv
// rtl/sgdmac_desc_fetcher_pv.sv - SGDMAC linked-descriptor fetcher feeding the command FIFO
//
// Walks a chain of descriptors over an AXI read port and pushes one
// {address, length} command per non-empty descriptor into the command FIFO.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start_ptr_i, start_i        first descriptor address, start request (IDLE only)
//   abort_i                     stop at the next descriptor boundary
//   done_o, error_o, desc_cnt_o status: idle, sticky error, descriptors processed
//   ar*_o / arready_i           AXI read address channel (one burst per descriptor)
//   r*_i / rready_o             AXI read data channel
//   afull_i                     command FIFO almost full
//   wren_o, wdata_o, rw_o       command FIFO write strobe, {address, length}, direction
module sgdmac_desc_fetcher_pv #(
    parameter int         LEN_W      = 16,
    parameter int         DESC_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           start_ptr_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           desc_cnt_o,
    output logic [3:0]            arid_o,
    output logic [31:0]           araddr_o,
    output logic [3:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic                  afull_i,
    output logic                  wren_o,
    output logic [32+LEN_W-1:0]   wdata_o,
    output logic                  rw_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_PUSH = 2'd3;

    localparam logic [4:0] LAST_BEAT = 5'(DESC_WORDS - 1);

    logic [1:0]            state;
    logic [31:0]           ptr;
    logic [31:0]           start_cpy;
    logic [15:0]           count;
    logic                  err;
    logic                  abort_lat;
    logic [4:0]            beat;
    logic                  burst_err;
    logic [31:0]           d_addr;
    logic [LEN_W-1:0]      d_len;
    logic                  d_rw;
    logic                  d_eoc;
    logic [31:0]           d_next;
    logic [32+LEN_W-1:0]   wdata_q;
    logic                  rw_q;

    logic                  beat_bad;
    logic                  leave_push;
    logic                  chain_end;

    // The ID is constant by construction; the bus field is kept for interface completeness.
    logic unused_rid;
    assign unused_rid = &{1'b0, rid_i};

    // A beat is bad on a slave error or when rlast disagrees with the expected burst length.
    assign beat_bad   = (rresp_i != 2'b00) || (rlast_i != (beat == LAST_BEAT));

    // Zero-length descriptors never write, so they need not wait for FIFO space.
    assign leave_push = (state == S_PUSH) && (!afull_i || (d_len == '0));

    // An abort arriving in the final PUSH cycle is honoured at this boundary too.
    assign chain_end  = d_eoc || (d_next == 32'd0) || (d_next == start_cpy) ||
                        abort_lat || abort_i;

    assign done_o     = (state == S_IDLE);
    assign error_o    = err;
    assign desc_cnt_o = count;
    assign arvalid_o  = (state == S_AR);
    assign araddr_o   = ptr;
    // Constant burst attributes are only presented alongside arvalid_o.
    assign arid_o     = arvalid_o ? AXI_ID : 4'd0;
    assign arlen_o    = arvalid_o ? 4'(DESC_WORDS - 1) : 4'd0;
    assign arsize_o   = arvalid_o ? 3'b010 : 3'b000;
    assign arburst_o  = arvalid_o ? 2'b01 : 2'b00;
    assign rready_o   = (state == S_R);
    assign wren_o     = (state == S_PUSH) && !afull_i && (d_len != '0);
    assign wdata_o    = wdata_q;
    assign rw_o       = rw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= 32'd0;
            start_cpy <= 32'd0;
            count     <= 16'd0;
            err       <= 1'b0;
            abort_lat <= 1'b0;
            beat      <= 5'd0;
            burst_err <= 1'b0;
            d_addr    <= 32'd0;
            d_len     <= '0;
            d_rw      <= 1'b0;
            d_eoc     <= 1'b0;
            d_next    <= 32'd0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
        end else begin
            if (abort_i && (state != S_IDLE)) begin
                abort_lat <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ptr       <= start_ptr_i;
                        start_cpy <= start_ptr_i;
                        count     <= 16'd0;
                        err       <= 1'b0;
                        abort_lat <= 1'b0;
                        state     <= S_AR;
                    end
                end

                S_AR: begin
                    if (arready_i) begin
                        beat      <= 5'd0;
                        burst_err <= 1'b0;
                        state     <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid_i) begin
                        case (beat)
                            5'd0:    d_addr <= rdata_i;
                            5'd1:    d_len  <= rdata_i[LEN_W-1:0];
                            5'd2:    begin
                                         d_rw  <= rdata_i[0];
                                         d_eoc <= rdata_i[1];
                                     end
                            5'd3:    d_next <= rdata_i;
                            default: ;
                        endcase
                        // Saturate so an overlong burst cannot wrap back onto a valid beat index.
                        if (beat != 5'd31) begin
                            beat <= beat + 5'd1;
                        end
                        if (beat_bad) begin
                            err       <= 1'b1;
                            burst_err <= 1'b1;
                        end
                        if (rlast_i) begin
                            if (burst_err || beat_bad) begin
                                state <= S_IDLE;
                            end else begin
                                // Address and length arrive on beats 0/1, always before rlast.
                                wdata_q <= {d_addr, d_len};
                                rw_q    <= d_rw;
                                state   <= S_PUSH;
                            end
                        end
                    end
                end

                S_PUSH: begin
                    if (leave_push) begin
                        if (count != 16'hFFFF) begin
                            count <= count + 16'd1;
                        end
                        if (chain_end) begin
                            state <= S_IDLE;
                        end else begin
                            ptr   <= d_next;
                            state <= S_AR;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
